// File: rtl/gray_code_converter.sv
// Registered binary->Gray and Gray->binary converter pair; GRAY_CODE_CONVERTER_CHECK_EN adds a round-trip checker (err_o).
// Latency: 1 cycle from valid_i to valid_o/gray_o/binary_o; err_o follows valid_o by one more cycle.
// Backpressure: none, a result is produced for every valid_i cycle and outputs hold when valid_i is low.
module gray_code_converter #(
  parameter int LENGTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [LENGTH-1:0] binary_i,
  input  logic [LENGTH-1:0] gray_i,
  output logic              valid_o,
  output logic [LENGTH-1:0] gray_o,
  output logic [LENGTH-1:0] binary_o
`ifdef GRAY_CODE_CONVERTER_CHECK_EN
  ,
  output logic              err_o
`endif
);

  // Bit k of the binary value is the XOR of every Gray bit at or above k.
  function automatic logic [LENGTH-1:0] gray_to_bin(input logic [LENGTH-1:0] g);
    logic [LENGTH-1:0] b;
    b = '0;
    for (int k = 0; k < LENGTH; k++) begin
      b[k] = ^(g >> k);
    end
    return b;
  endfunction

  logic              vld_q;
  logic [LENGTH-1:0] gray_q;
  logic [LENGTH-1:0] bin_q;
  logic [LENGTH-1:0] gray_nxt;
  logic [LENGTH-1:0] bin_nxt;

  assign gray_nxt = binary_i ^ (binary_i >> 1);
  assign bin_nxt  = gray_to_bin(gray_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      gray_q <= '0;
      bin_q  <= '0;
    end else begin
      vld_q <= valid_i;
      if (valid_i) begin
        gray_q <= gray_nxt;
        bin_q  <= bin_nxt;
      end
    end
  end

  assign valid_o  = vld_q;
  assign gray_o   = gray_q;
  assign binary_o = bin_q;

`ifdef GRAY_CODE_CONVERTER_CHECK_EN
  logic [LENGTH-1:0] src_bin_q;
  logic              err_q;

  // Keep the original binary so the registered Gray can be decoded and compared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_bin_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (valid_i) begin
        src_bin_q <= binary_i;
      end
      err_q <= vld_q && (gray_to_bin(gray_q) != src_bin_q);
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_gray_code_converter.sv
// Scoreboard/table bench for gray_code_converter at LENGTH 4, 1 and 8.
module tb_gray_code_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v4, v4o;
  logic [3:0] b4, g4i, g4o, b4o;
  logic       v1, v1o;
  logic [0:0] b1, g1i, g1o, b1o;
  logic       v8, v8o;
  logic [7:0] b8, g8i, g8o, b8o;
`ifdef GRAY_CODE_CONVERTER_CHECK_EN
  logic       err4, err1, err8;
`endif

  gray_code_converter #(.LENGTH(4)) u4 (
    .clk_i(clk), .rst_i(rst), .valid_i(v4), .binary_i(b4), .gray_i(g4i),
    .valid_o(v4o), .gray_o(g4o), .binary_o(b4o)
`ifdef GRAY_CODE_CONVERTER_CHECK_EN
    , .err_o(err4)
`endif
  );

  gray_code_converter #(.LENGTH(1)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .binary_i(b1), .gray_i(g1i),
    .valid_o(v1o), .gray_o(g1o), .binary_o(b1o)
`ifdef GRAY_CODE_CONVERTER_CHECK_EN
    , .err_o(err1)
`endif
  );

  gray_code_converter #(.LENGTH(8)) u8 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8), .binary_i(b8), .gray_i(g8i),
    .valid_o(v8o), .gray_o(g8o), .binary_o(b8o)
`ifdef GRAY_CODE_CONVERTER_CHECK_EN
    , .err_o(err8)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] b;
  } exp4_t;
  exp4_t sb[$];

  typedef struct {
    logic       v;
    logic [3:0] bin;
    logic [3:0] gry;
    logic [3:0] eg;
    logic [3:0] eb;
  } vec_t;
  vec_t tab[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_enc(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] m_dec(input logic [7:0] g, input int n);
    logic [7:0] r;
    logic       acc;
    r   = '0;
    acc = 1'b0;
    for (int k = n - 1; k >= 0; k--) begin
      acc  = acc ^ g[k];
      r[k] = acc;
    end
    return r;
  endfunction

  task automatic sb_check4(input string name);
    exp4_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_gray"}, {28'd0, g4o}, {28'd0, e.g});
      chk({name, "_bin"}, {28'd0, b4o}, {28'd0, e.b});
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_v4"}, {31'd0, v4o}, 32'd0);
    chk({name, "_g4"}, {28'd0, g4o}, 32'd0);
    chk({name, "_b4"}, {28'd0, b4o}, 32'd0);
    chk({name, "_v1"}, {31'd0, v1o}, 32'd0);
    chk({name, "_g1b1"}, {30'd0, g1o, b1o}, 32'd0);
    chk({name, "_v8"}, {31'd0, v8o}, 32'd0);
    chk({name, "_g8b8"}, {16'd0, g8o, b8o}, 32'd0);
`ifdef GRAY_CODE_CONVERTER_CHECK_EN
    chk({name, "_err"}, {29'd0, err4, err1, err8}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_b, prev_g;
    logic [7:0] e8;
    bit         have_g;

    tab[0] = '{1'b1, 4'b0110, 4'b1000, 4'b0101, 4'b1111};
    tab[1] = '{1'b1, 4'b1111, 4'b1111, 4'b1000, 4'b1010};
    tab[2] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tab[3] = '{1'b0, 4'b1010, 4'b0101, 4'b0000, 4'b0000};
    tab[4] = '{1'b1, 4'b1010, 4'b0101, 4'b1111, 4'b0110};
    tab[5] = '{1'b1, 4'b1000, 4'b0001, 4'b1100, 4'b0001};
    tab[6] = '{1'b0, 4'b0011, 4'b1100, 4'b1100, 4'b0001};
    tab[7] = '{1'b0, 4'b1111, 4'b0000, 4'b1100, 4'b0001};
    tab[8] = '{1'b0, 4'b0101, 4'b1010, 4'b1100, 4'b0001};
    tab[9] = '{1'b1, 4'b0111, 4'b1101, 4'b0100, 4'b1001};

    rst = 1'b0;
    v4 = 1'b0; b4 = '0; g4i = '0;
    v1 = 1'b0; b1 = '0; g1i = '0;
    v8 = 1'b0; b8 = '0; g8i = '0;

    // Reset asserted between clock edges must clear outputs immediately.
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk_zero("rst_idle");
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v4 = tab[i].v; b4 = tab[i].bin; g4i = tab[i].gry;
      if (tab[i].v) sb.push_back('{tab[i].eg, tab[i].eb});
      @(posedge clk); #1;
      chk("tab_vld", {31'd0, v4o}, {31'd0, tab[i].v});
      if (v4o) begin
        sb_check4("tab");
      end else begin
        chk("tab_hold_gray", {28'd0, g4o}, {28'd0, tab[i].eg});
        chk("tab_hold_bin", {28'd0, b4o}, {28'd0, tab[i].eb});
      end
    end

    // Loopback sweep with wrap, interrupted by a reset mid-stream.
    prev_b = 4'b0111;
    prev_g = '0;
    have_g = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) begin
        @(negedge clk);
        v4 = 1'b0;
        #1 rst = 1'b1;
        #1 chk_zero("rst_mid");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        prev_b = '0;
        have_g = 1'b0;
      end
      @(negedge clk);
      v4 = 1'b1;
      b4 = 4'(i % 16);
      g4i = g4o;
      e8 = m_enc({4'd0, b4});
      sb.push_back('{e8[3:0], prev_b});
      prev_b = b4;
      @(posedge clk); #1;
      chk("sweep_vld", {31'd0, v4o}, 32'd1);
      sb_check4("sweep");
      if (have_g) chk("sweep_gray_1bit", $countones(g4o ^ prev_g), 32'd1);
      prev_g = g4o;
      have_g = 1'b1;
`ifdef GRAY_CODE_CONVERTER_CHECK_EN
      chk("sweep_err", {31'd0, err4}, 32'd0);
`endif
    end

`ifdef GRAY_CODE_CONVERTER_CHECK_EN
    @(negedge clk);
    v4 = 1'b1; b4 = 4'b0011; g4i = '0;
    @(posedge clk); #1;
    chk("err_pre", {31'd0, err4}, 32'd0);
    @(negedge clk);
    v4 = 1'b0;
    force u4.gray_q = 4'b0011;
    @(posedge clk); #1;
    chk("err_pulse", {31'd0, err4}, 32'd1);
    @(negedge clk);
    release u4.gray_q;
    @(posedge clk); #1;
    chk("err_clear", {31'd0, err4}, 32'd0);
`endif

    @(negedge clk);
    v4 = 1'b0;

    // LENGTH=8 full sweep with random Gray inputs, LENGTH=1 exhaustive.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v8 = 1'b1; b8 = 8'(i); g8i = 8'($urandom);
      v1 = 1'b1; b1 = 1'(i); g1i = 1'(i >> 1);
      @(posedge clk); #1;
      chk("len8_vld", {31'd0, v8o}, 32'd1);
      chk("len8_gray", {24'd0, g8o}, {24'd0, m_enc(b8)});
      chk("len8_bin", {24'd0, b8o}, {24'd0, m_dec(g8i, 8)});
      if (i < 4) begin
        chk("len1_vld", {31'd0, v1o}, 32'd1);
        chk("len1_gray", {31'd0, g1o}, {31'd0, b1});
        chk("len1_bin", {31'd0, b1o}, {31'd0, g1i});
      end
    end
    chk("len8_ff_gray", {24'd0, g8o}, 32'h80);

    @(negedge clk);
    v8 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    chk("len8_idle_vld", {31'd0, v8o}, 32'd0);
    chk("len8_idle_hold", {24'd0, g8o}, 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
